// File: rtl/csa_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined carry-save adder tree.
// Row bookkeeping: level 0 holds the NUM_OPS input rows; each later level holds the rows left after one 3:2 compression pass.
package csa_pkg;

  localparam int unsigned NUM_OPS_MIN = 3;
  localparam int unsigned NUM_OPS_MAX = 16;
  localparam int unsigned WIDTH_MIN   = 1;
  localparam int unsigned WIDTH_MAX   = 64;

  // Rows remaining after one level of 3:2 compression.
  function automatic int unsigned csa_next(input int unsigned n);
    return 2 * (n / 3) + (n % 3);
  endfunction

  function automatic int unsigned csa_levels(input int unsigned n);
    int unsigned rows;
    int unsigned lv;
    rows = n;
    lv   = 0;
    while (rows > 2) begin
      rows = csa_next(rows);
      lv++;
    end
    return lv;
  endfunction

  function automatic int unsigned csa_rows(input int unsigned n, input int unsigned lvl);
    int unsigned rows;
    rows = n;
    for (int unsigned i = 0; i < lvl; i++) rows = csa_next(rows);
    return rows;
  endfunction

  // Row offset of level lvl inside a flat concatenation of levels 0..lvl-1.
  function automatic int unsigned csa_row_off(input int unsigned n, input int unsigned lvl);
    int unsigned off;
    off = 0;
    for (int unsigned i = 0; i < lvl; i++) off += csa_rows(n, i);
    return off;
  endfunction

  function automatic int unsigned csa_out_w(input int unsigned width, input int unsigned n);
    return width + $clog2(n);
  endfunction

endpackage

// File: rtl/csa_row.sv
// One row of W-bit 3:2 compressors; the carry vector is returned already aligned (shifted left 1, top carry dropped).
module csa_row #(
  parameter int unsigned W = 19
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  output logic [W-1:0] sum_o,
  output logic [W-1:0] carry_o
);

  assign sum_o   = a_i ^ b_i ^ c_i;
  assign carry_o = ((a_i & b_i) | (a_i & c_i) | (b_i & c_i)) << 1;

endmodule

// File: rtl/csa_tree_pipe.sv
// Pipelined Wallace tree of 3:2 compressors with valid/ready flow control, one register stage per level.
// Optional macro CSA_TREE_PIPE_CPA_EN appends a carry-propagate stage driving out_result.
module csa_tree_pipe
  import csa_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned NUM_OPS = 8,
  localparam int unsigned OUT_W  = csa_out_w(WIDTH, NUM_OPS),
  localparam int unsigned LEVELS = csa_levels(NUM_OPS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_OPS*WIDTH-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_sum,
`ifdef CSA_TREE_PIPE_CPA_EN
  output logic [OUT_W-1:0]         out_carry,
  output logic [OUT_W-1:0]         out_result
`else
  output logic [OUT_W-1:0]         out_carry
`endif
);

  if (NUM_OPS < NUM_OPS_MIN || NUM_OPS > NUM_OPS_MAX ||
      WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_cfg_check
    $error("csa_tree_pipe: illegal configuration NUM_OPS=%0d WIDTH=%0d", NUM_OPS, WIDTH);
  end

  localparam int unsigned ALL_ROWS = csa_row_off(NUM_OPS, LEVELS + 1);
  localparam int unsigned REG_ROWS = ALL_ROWS - NUM_OPS;
  localparam int unsigned LAST_OFF = csa_row_off(NUM_OPS, LEVELS) - NUM_OPS;

  // Every level lives in one flat vector; a per-bit load mask lets a single process own all data registers.
  logic [NUM_OPS*OUT_W-1:0]  lvl0;
  logic [REG_ROWS*OUT_W-1:0] rows_q, rows_d, rows_mask;
  logic [ALL_ROWS*OUT_W-1:0] all_rows;
  logic [LEVELS-1:0]         vld_q, src_v, ld, upd;
  logic                      tail_ready;
  logic [OUT_W-1:0]          tree_sum, tree_carry;

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_zext
    assign lvl0[i*OUT_W +: OUT_W] = OUT_W'(in_data[i*WIDTH +: WIDTH]);
  end

  assign all_rows = {rows_q, lvl0};

  for (genvar l = 1; l <= LEVELS; l++) begin : g_level
    localparam int unsigned NIN  = csa_rows(NUM_OPS, l - 1);
    localparam int unsigned NOUT = csa_rows(NUM_OPS, l);
    localparam int unsigned NG   = NIN / 3;
    localparam int unsigned NR   = NIN % 3;
    localparam int unsigned IOFF = csa_row_off(NUM_OPS, l - 1);
    localparam int unsigned OOFF = csa_row_off(NUM_OPS, l) - NUM_OPS;

    for (genvar g = 0; g < NG; g++) begin : g_grp
      csa_row #(.W(OUT_W)) u_row (
        .a_i    (all_rows[(IOFF + 3*g)     * OUT_W +: OUT_W]),
        .b_i    (all_rows[(IOFF + 3*g + 1) * OUT_W +: OUT_W]),
        .c_i    (all_rows[(IOFF + 3*g + 2) * OUT_W +: OUT_W]),
        .sum_o  (rows_d[(OOFF + 2*g)     * OUT_W +: OUT_W]),
        .carry_o(rows_d[(OOFF + 2*g + 1) * OUT_W +: OUT_W])
      );
    end

    for (genvar r = 0; r < NR; r++) begin : g_pass
      assign rows_d[(OOFF + 2*NG + r) * OUT_W +: OUT_W] = all_rows[(IOFF + 3*NG + r) * OUT_W +: OUT_W];
    end

    assign rows_mask[OOFF*OUT_W +: NOUT*OUT_W] = {(NOUT*OUT_W){upd[l-1]}};
  end

  always_comb begin
    src_v    = '0;
    src_v[0] = in_valid;
    for (int unsigned s = 1; s < LEVELS; s++) src_v[s] = vld_q[s-1];
  end

  // A stage loads when empty or when its successor loads, so bubbles collapse under a stalled output.
  always_comb begin
    ld           = '0;
    ld[LEVELS-1] = !vld_q[LEVELS-1] || tail_ready;
    for (int unsigned k = 1; k < LEVELS; k++) ld[LEVELS-1-k] = !vld_q[LEVELS-1-k] || ld[LEVELS-k];
  end

  assign upd      = ld & src_v;
  assign in_ready = ld[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_q <= '0;
      vld_q  <= '0;
    end else begin
      rows_q <= (rows_q & ~rows_mask) | (rows_d & rows_mask);
      vld_q  <= (vld_q & ~ld) | (src_v & ld);
    end
  end

  assign tree_sum   = rows_q[LAST_OFF*OUT_W       +: OUT_W];
  assign tree_carry = rows_q[(LAST_OFF + 1)*OUT_W +: OUT_W];

`ifdef CSA_TREE_PIPE_CPA_EN
  logic             cpa_vld_q;
  logic [OUT_W-1:0] cpa_sum_q, cpa_carry_q, cpa_res_q;

  assign tail_ready = !cpa_vld_q || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpa_vld_q   <= 1'b0;
      cpa_sum_q   <= '0;
      cpa_carry_q <= '0;
      cpa_res_q   <= '0;
    end else if (tail_ready) begin
      cpa_vld_q <= vld_q[LEVELS-1];
      if (vld_q[LEVELS-1]) begin
        cpa_sum_q   <= tree_sum;
        cpa_carry_q <= tree_carry;
        cpa_res_q   <= tree_sum + tree_carry;
      end
    end
  end

  assign out_valid  = cpa_vld_q;
  assign out_sum    = cpa_sum_q;
  assign out_carry  = cpa_carry_q;
  assign out_result = cpa_res_q;
`else
  assign tail_ready = out_ready;
  assign out_valid  = vld_q[LEVELS-1];
  assign out_sum    = tree_sum;
  assign out_carry  = tree_carry;
`endif

endmodule

// File: tb/tb_csa_tree_pipe.sv
// Self-checking bench for csa_tree_pipe: three configurations (8x16, 3x8, 16x12) against an arithmetic sum model.
module tb_csa_tree_pipe;

  localparam int W    = 16;
  localparam int N    = 8;
  localparam int OW   = 19;
  localparam int LV   = 4;
  localparam int W3   = 8;
  localparam int N3   = 3;
  localparam int OW3  = 10;
  localparam int LV3  = 1;
  localparam int W16  = 12;
  localparam int N16  = 16;
  localparam int OW16 = 16;
  localparam int LV16 = 6;
`ifdef CSA_TREE_PIPE_CPA_EN
  localparam int CPA = 1;
`else
  localparam int CPA = 0;
`endif
  localparam int LAT   = LV + CPA;
  localparam int LAT3  = LV3 + CPA;
  localparam int LAT16 = LV16 + CPA;

  logic clk;
  logic rst_n;

  logic              in_valid, in_ready, out_valid, out_ready;
  logic [N*W-1:0]    in_data;
  logic [OW-1:0]     out_sum, out_carry;
  logic              in_valid3, in_ready3, out_valid3, out_ready3;
  logic [N3*W3-1:0]  in_data3;
  logic [OW3-1:0]    out_sum3, out_carry3;
  logic              in_valid16, in_ready16, out_valid16, out_ready16;
  logic [N16*W16-1:0] in_data16;
  logic [OW16-1:0]   out_sum16, out_carry16;
`ifdef CSA_TREE_PIPE_CPA_EN
  logic [OW-1:0]     out_result;
  logic [OW3-1:0]    out_result3;
  logic [OW16-1:0]   out_result16;
`endif

  int checks   = 0;
  int failures = 0;

  csa_tree_pipe #(.WIDTH(W), .NUM_OPS(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
`ifdef CSA_TREE_PIPE_CPA_EN
    .out_carry(out_carry), .out_result(out_result)
`else
    .out_carry(out_carry)
`endif
  );

  csa_tree_pipe #(.WIDTH(W3), .NUM_OPS(N3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_sum(out_sum3),
`ifdef CSA_TREE_PIPE_CPA_EN
    .out_carry(out_carry3), .out_result(out_result3)
`else
    .out_carry(out_carry3)
`endif
  );

  csa_tree_pipe #(.WIDTH(W16), .NUM_OPS(N16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16), .in_data(in_data16),
    .out_valid(out_valid16), .out_ready(out_ready16), .out_sum(out_sum16),
`ifdef CSA_TREE_PIPE_CPA_EN
    .out_carry(out_carry16), .out_result(out_result16)
`else
    .out_carry(out_carry16)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [N*W-1:0] rand_main();
    logic [N*W-1:0] d;
    for (int i = 0; i < N; i++) d[i*W +: W] = W'($urandom);
    return d;
  endfunction

  function automatic logic [OW-1:0] model_main(input logic [N*W-1:0] d);
    logic [OW-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) s = s + OW'(d[i*W +: W]);
    return s;
  endfunction

  function automatic logic [N16*W16-1:0] rand16();
    logic [N16*W16-1:0] d;
    for (int i = 0; i < N16; i++) d[i*W16 +: W16] = W16'($urandom);
    return d;
  endfunction

  function automatic logic [OW16-1:0] model16(input logic [N16*W16-1:0] d);
    logic [OW16-1:0] s;
    s = '0;
    for (int i = 0; i < N16; i++) s = s + OW16'(d[i*W16 +: W16]);
    return s;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 0; in_data = '0; out_ready = 0;
    in_valid3 = 0; in_data3 = '0; out_ready3 = 0;
    in_valid16 = 0; in_data16 = '0; out_ready16 = 0;
    #3;
    checks++;
    if (out_valid !== 1'b0 || out_sum !== '0 || out_carry !== '0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b s=%h c=%h exp v=0 s=0 c=0", out_valid, out_sum, out_carry);
    end
    checks++;
    if (in_ready !== 1'b1 || in_ready3 !== 1'b1 || in_ready16 !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got %b%b%b exp 111", in_ready, in_ready3, in_ready16);
    end
    checks++;
    if (out_valid3 !== 1'b0 || out_valid16 !== 1'b0) begin
      failures++;
      $display("FAIL reset_small_wide_valid got %b%b exp 00", out_valid3, out_valid16);
    end
`ifdef CSA_TREE_PIPE_CPA_EN
    checks++;
    if (out_result !== '0) begin
      failures++;
      $display("FAIL reset_result got=%h exp=0", out_result);
    end
`endif
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_in_ready got=%b exp=1", in_ready);
    end
  endtask

  // Single sets: all-ones and ascending operands 1..8, checking latency and value.
  task automatic test_single_sets();
    logic [N*W-1:0] d;
    logic [OW-1:0]  exp_v, got;
    int             at, nout;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < N; i++) d[i*W +: W] = (p == 0) ? W'(16'hFFFF) : W'(i + 1);
      exp_v = (p == 0) ? OW'(19'h7FFF8) : OW'(36);
      at = -1; nout = 0;
      for (int c = 0; c < LAT + 5; c++) begin
        @(posedge clk); #1;
        in_valid = (c == 0); in_data = d; out_ready = 1'b1;
        #1;
        if (out_valid === 1'b1) begin
          nout++;
          if (at < 0) at = c;
          got = out_sum + out_carry;
          checks++;
          if (got !== exp_v) begin
            failures++;
            $display("FAIL single_value pattern=%0d got=%h exp=%h", p, got, exp_v);
          end
`ifdef CSA_TREE_PIPE_CPA_EN
          checks++;
          if (out_result !== exp_v) begin
            failures++;
            $display("FAIL single_result pattern=%0d got=%h exp=%h", p, out_result, exp_v);
          end
`endif
        end
      end
      checks++;
      if (at != LAT || nout != 1) begin
        failures++;
        $display("FAIL single_latency pattern=%0d got_cycle=%0d got_count=%0d exp_cycle=%0d exp_count=1", p, at, nout, LAT);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [OW-1:0] q[$];
    logic [OW-1:0] got, e;
    int first, last, nout;
    first = -1; last = -1; nout = 0;
    for (int c = 0; c < 10 + LAT + 3; c++) begin
      @(posedge clk); #1;
      in_valid = (c < 10); in_data = rand_main(); out_ready = 1'b1;
      #1;
      if (out_valid === 1'b1) begin
        nout++;
        if (first < 0) first = c;
        last = c;
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL b2b_unexpected_output cycle=%0d got_valid=1 exp_valid=0", c);
        end else begin
          e = q.pop_front();
          got = out_sum + out_carry;
          if (got !== e) begin
            failures++;
            $display("FAIL b2b_value cycle=%0d got=%h exp=%h", c, got, e);
          end
        end
      end
      if (in_valid) begin
        checks++;
        if (in_ready !== 1'b1) begin
          failures++;
          $display("FAIL b2b_in_ready cycle=%0d got=%b exp=1", c, in_ready);
        end
        q.push_back(model_main(in_data));
      end
    end
    checks++;
    if (nout != 10 || first != LAT || last - first != 9) begin
      failures++;
      $display("FAIL b2b_stream got_count=%0d first=%0d last=%0d exp_count=10 first=%0d last=%0d", nout, first, last, LAT, LAT + 9);
    end
  endtask

  task automatic test_stall();
    logic [OW-1:0] q[$];
    logic [OW-1:0] hs, hc, got, e;
    logic held;
    int acc, nout;
    held = 1'b0; acc = 0; nout = 0; hs = '0; hc = '0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = rand_main(); out_ready = 1'b0;
      #1;
      if (held) begin
        checks++;
        if (out_valid !== 1'b1 || out_sum !== hs || out_carry !== hc) begin
          failures++;
          $display("FAIL stall_hold cycle=%0d got v=%b s=%h c=%h exp v=1 s=%h c=%h", c, out_valid, out_sum, out_carry, hs, hc);
        end
      end else if (out_valid === 1'b1) begin
        held = 1'b1; hs = out_sum; hc = out_carry;
      end
      if (in_ready === 1'b1) begin
        acc++;
        q.push_back(model_main(in_data));
      end
    end
    checks++;
    if (acc != LAT) begin
      failures++;
      $display("FAIL stall_accepted got=%0d exp=%0d", acc, LAT);
    end
    checks++;
    if (in_ready !== 1'b0 || held !== 1'b1) begin
      failures++;
      $display("FAIL stall_full got in_ready=%b out_seen=%b exp in_ready=0 out_seen=1", in_ready, held);
    end
    for (int c = 0; c < LAT + 4; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      if (out_valid === 1'b1) begin
        nout++;
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL stall_extra_output cycle=%0d got_valid=1 exp_valid=0", c);
        end else begin
          e = q.pop_front();
          got = out_sum + out_carry;
          if (got !== e) begin
            failures++;
            $display("FAIL stall_drain_value cycle=%0d got=%h exp=%h", c, got, e);
          end
`ifdef CSA_TREE_PIPE_CPA_EN
          if (out_result !== e) begin
            failures++;
            $display("FAIL stall_drain_result cycle=%0d got=%h exp=%h", c, out_result, e);
          end
`endif
        end
      end
    end
    checks++;
    if (nout != acc) begin
      failures++;
      $display("FAIL stall_drain_count got=%0d exp=%0d", nout, acc);
    end
  endtask

  task automatic test_reset_midflight();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      in_valid = (c < 3); in_data = rand_main(); out_ready = 1'b0;
      #1;
    end
    @(posedge clk); #2;
    checks++;
    if (out_valid !== (CPA == 0)) begin
      failures++;
      $display("FAIL flight_pre_reset_valid got=%b exp=%b", out_valid, (CPA == 0));
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_sum !== '0 || out_carry !== '0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flight_async_clear got v=%b s=%h c=%h rdy=%b exp v=0 s=0 c=0 rdy=1", out_valid, out_sum, out_carry, in_ready);
    end
    #3 rst_n = 1'b1;
    for (int c = 0; c < 10 + LAT; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL flight_stale_result cycle=%0d got_valid=%b exp_valid=0", c, out_valid);
      end
    end
  endtask

  task automatic test_random_stall();
    logic [OW-1:0] q[$];
    logic [OW-1:0] got, e;
    for (int c = 0; c < 200 + LAT + 4; c++) begin
      @(posedge clk); #1;
      in_valid  = (c < 200) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data   = rand_main();
      out_ready = (c < 200) ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL rand_unexpected_output cycle=%0d got_valid=1 exp_valid=0", c);
        end else begin
          e = q.pop_front();
          got = out_sum + out_carry;
          if (got !== e) begin
            failures++;
            $display("FAIL rand_value cycle=%0d got=%h exp=%h", c, got, e);
          end
        end
      end
      if (in_valid && in_ready === 1'b1) q.push_back(model_main(in_data));
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL rand_lost_sets got_pending=%0d exp_pending=0", q.size());
    end
  endtask

  task automatic test_idle();
    logic [OW-1:0] hs, hc;
    hs = out_sum; hc = out_carry;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b0; in_data = rand_main(); out_ready = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_sum !== hs || out_carry !== hc) begin
        failures++;
        $display("FAIL idle_stable cycle=%0d got v=%b s=%h c=%h exp v=0 s=%h c=%h", c, out_valid, out_sum, out_carry, hs, hc);
      end
    end
  endtask

  task automatic test_small_tree();
    logic [OW3-1:0] got;
    int at;
    at = -1;
    for (int c = 0; c < LAT3 + 4; c++) begin
      @(posedge clk); #1;
      in_valid3 = (c == 0); in_data3 = {8'd3, 8'd2, 8'd1}; out_ready3 = 1'b1;
      #1;
      if (out_valid3 === 1'b1 && at < 0) begin
        at = c;
        got = out_sum3 + out_carry3;
        checks++;
        if (got !== OW3'(6)) begin
          failures++;
          $display("FAIL small_value got=%0d exp=6", got);
        end
      end
    end
    checks++;
    if (at != LAT3) begin
      failures++;
      $display("FAIL small_latency got=%0d exp=%0d", at, LAT3);
    end
    in_valid3 = 1'b0;
  endtask

  task automatic test_wide_random();
    logic [OW16-1:0] q[$];
    logic [OW16-1:0] got, e;
    int nout;
    nout = 0;
    for (int c = 0; c < 250 + LAT16 + 4; c++) begin
      @(posedge clk); #1;
      in_valid16  = (c < 250) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data16   = rand16();
      out_ready16 = (c < 250) ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (out_valid16 === 1'b1 && out_ready16) begin
        nout++;
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL wide_unexpected_output cycle=%0d got_valid=1 exp_valid=0", c);
        end else begin
          e = q.pop_front();
          got = out_sum16 + out_carry16;
          if (got !== e) begin
            failures++;
            $display("FAIL wide_value cycle=%0d got=%h exp=%h", c, got, e);
          end
        end
      end
      if (in_valid16 && in_ready16 === 1'b1) q.push_back(model16(in_data16));
    end
    checks++;
    if (q.size() != 0 || nout == 0) begin
      failures++;
      $display("FAIL wide_drain got_pending=%0d got_outputs=%0d exp_pending=0 exp_outputs>0", q.size(), nout);
    end
  endtask

  initial begin
    test_reset();
    test_single_sets();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    test_random_stall();
    test_idle();
    test_small_tree();
    test_wide_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/csa_tree_pipe.md
CSA_TREE_PIPE -- requirements
Module: csa_tree_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand bit width (1..64).
REQ-002 SHALL have parameter NUM_OPS, default 8, operand count (3..16).
REQ-003 SHALL derive localparam OUT_W = WIDTH + $clog2(NUM_OPS) and localparam LEVELS = csa_levels(NUM_OPS).
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
REQ-005 Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand set valid.
- in_ready  output  1  block accepts the operand set.
- in_data  input  NUM_OPS*WIDTH  unsigned operands; operand i occupies bits [i*WIDTH +: WIDTH].
- out_valid  output  1  result valid.
- out_ready  input  1  sink accepts the result.
- out_sum  output  OUT_W  redundant sum vector.
- out_carry  output  OUT_W  redundant carry vector, already aligned (shifted left 1).
- out_result  output  OUT_W  binary result; present only with CSA_TREE_PIPE_CPA_EN.

Function
REQ-006 SHALL reduce NUM_OPS operands by a Wallace tree of 3:2 compressors: each level maps n rows to 2*floor(n/3) + (n mod 3) rows until 2 rows remain.
REQ-007 SHALL register every compressor level, so there are LEVELS pipeline stages; 3->1, 4->2, 5..6->3, 7..9->4, 10..13->5, 14..16->6.
REQ-008 SHALL guarantee (out_sum + out_carry) mod 2^OUT_W = sum of the operands; no overflow is possible for unsigned inputs.
REQ-009 SHALL zero-extend operands to OUT_W and discard carries beyond bit OUT_W-1.
REQ-010 A transfer SHALL occur on each port when valid and ready are both high at a rising clk edge.
REQ-011 Stage k SHALL load when its valid bit is 0 or stage k+1 loads (the last stage uses out_ready); in_ready = stage-0 load condition (combinational ready chain permitted).
REQ-012 Latency in_valid&in_ready to out_valid SHALL be exactly LEVELS cycles with no stall; throughput 1 set/cycle with out_ready held high.
REQ-013 Bubbles SHALL collapse: a stalled output does not block upstream stages that are empty.
REQ-014 out_valid, out_sum, out_carry (and out_result) SHALL hold stable while out_valid=1 and out_ready=0.
REQ-015 Registers SHALL not change when in_valid=0 and the pipeline is empty; no spurious out_valid.

Reset
REQ-016 rst_n low SHALL asynchronously clear all stage valid bits and data registers to 0: out_valid=0, out_sum=0, out_carry=0, out_result=0.
REQ-017 in_ready SHALL read 1 during and immediately after reset.
REQ-018 Reset mid-operation SHALL discard all in-flight sets; no pre-reset result appears after release.

Configuration
REQ-019 Macro CSA_TREE_PIPE_CPA_EN defined: SHALL append one register stage that computes out_result = out_sum + out_carry (mod 2^OUT_W); latency LEVELS+1; out_sum/out_carry are delayed to the same stage.
REQ-020 Macro undefined: out_result port SHALL be absent; latency LEVELS; output is redundant form only.

Structure
REQ-021 Package csa_pkg SHALL hold function csa_levels(n), function csa_out_w(width,n), and the NUM_OPS/WIDTH legal-range constants.
REQ-022 Sub-module csa_row SHALL implement one OUT_W-bit row of 3:2 compressors (sum = XOR3, carry = majority, shifted left 1); the tree instantiates it per level and group.
REQ-023 An elaboration-time check SHALL reject NUM_OPS or WIDTH outside the legal range.

Verification (WIDTH=16, NUM_OPS=8, OUT_W=19, LEVELS=4 unless stated)
REQ-024 All operands 16'hFFFF, out_ready=1 -> out_valid at cycle 4; out_sum+out_carry = 19'h7FFF8.
REQ-025 10 back-to-back random sets, out_ready=1 -> in_ready stays 1; 10 results on consecutive cycles, in order, matching the reference model.
REQ-026 out_ready=0 for 8 cycles with a continuous input stream -> exactly 4 sets accepted, then in_ready=0; outputs held stable; after release, results drain in order with no loss or duplicate.
REQ-027 rst_n pulsed low with 3 sets in flight -> out_valid=0 immediately (asynchronous); no result emerges within 10 cycles after release.
REQ-028 CSA_TREE_PIPE_CPA_EN defined, operands 1..8 -> out_result=36 at cycle 5.
REQ-029 NUM_OPS=3, operands 1,2,3 -> out_valid at cycle 1, out_sum+out_carry=6; random stalls with NUM_OPS=16 compared against the scoreboard.
